uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 17 +
 rtl/rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM state, default datapath sizes and an index-width helper.
package uart_pkg;

  localparam int unsigned UartDataW = 8;
  localparam int unsigned UartNReq  = 4;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping to 0.
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned N   = UartNReq,
  parameter int unsigned IdW = idx_width(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IdW-1:0] i_ptr,
  output logic [IdW-1:0] o_idx,
  output logic           o_any
);

  assign o_any = |i_req;

  // Descending scan so the closest request to the pointer is written last and wins.
  always_comb begin
    o_idx = '0;
    for (int j = 0; j < N; j++) begin
      if (i_ptr == IdW'(j)) begin
        for (int k = N - 1; k >= 0; k--) begin
          if (i_req[(j + k) % N]) begin
            o_idx = IdW'((j + k) % N);
          end
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter giving N_REQ byte sources message-level access to one UART transmitter.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ     = UartNReq,
  parameter int unsigned DATA_W    = UartDataW,
  parameter int unsigned MAX_BURST = 16,
  localparam int unsigned IdW      = idx_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_valid,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_ready,
  output logic [IdW-1:0]          grant_id,
  output logic                    busy
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  arb_state_e      r_state, w_state_next;
  logic [IdW-1:0]  r_rr_ptr, w_rr_ptr_next;
  logic [IdW-1:0]  r_grant, w_grant_next;
  logic [CntW-1:0] r_burst_cnt, w_burst_cnt_next;

  logic [IdW-1:0]    w_pick_idx;
  logic              w_pick_any;
  logic              w_gvalid;
  logic              w_glast;
  logic [DATA_W-1:0] w_gdata;
  logic              w_in_grant;
  logic              w_hs;
  logic [CntW-1:0]   w_cnt_inc;
  logic              w_burst_max;
  logic              w_release;
  logic [IdW-1:0]    w_grant_succ;

  rr_pick #(
    .N   (N_REQ),
    .IdW (IdW)
  ) u_rr_pick (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Mux the granted requester's lane out of the flat request bus.
  always_comb begin
    w_gvalid = 1'b0;
    w_glast  = 1'b0;
    w_gdata  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant == IdW'(i)) begin
        w_gvalid = req_valid[i];
        w_glast  = req_last[i];
        w_gdata  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_in_grant   = (r_state == StGrant);
  assign w_hs         = w_in_grant & w_gvalid & tx_ready;
  assign w_cnt_inc    = r_burst_cnt + 1'b1;
  assign w_burst_max  = (w_cnt_inc == CntW'(MAX_BURST));
  assign w_release    = w_hs & (w_glast | w_burst_max);
  assign w_grant_succ = (r_grant == IdW'(N_REQ - 1)) ? '0 : r_grant + 1'b1;

  always_comb begin
    w_state_next     = r_state;
    w_rr_ptr_next    = r_rr_ptr;
    w_grant_next     = r_grant;
    w_burst_cnt_next = r_burst_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_pick_any) begin
          w_grant_next     = w_pick_idx;
          w_burst_cnt_next = '0;
          w_state_next     = StGrant;
        end
      end
      StGrant: begin
        if (w_hs) begin
          w_burst_cnt_next = w_cnt_inc;
        end
        if (w_release) begin
          w_state_next  = StIdle;
          w_rr_ptr_next = w_grant_succ;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_rr_ptr    <= w_rr_ptr_next;
      r_grant     <= w_grant_next;
      r_burst_cnt <= w_burst_cnt_next;
    end
  end

  // Ready mirrors tx_ready on the granted lane even while that requester is stalled.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = w_in_grant & tx_ready & (r_grant == IdW'(i));
    end
  end

  assign tx_valid = w_in_grant & w_gvalid;
  assign tx_data  = tx_valid ? w_gdata : '0;
  assign grant_id = r_grant;
  assign busy     = w_in_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with four modelled byte requesters.
module tb_uart_tx_arbiter;

  localparam int unsigned NReq = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned MaxB = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NReq-1:0]    req_valid;
  logic [NReq*DW-1:0] req_data;
  logic [NReq-1:0]    req_last;
  logic [NReq-1:0]    req_ready;
  logic               tx_valid;
  logic [DW-1:0]      tx_data;
  logic               tx_ready;
  logic [1:0]         grant_id;
  logic               busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ     (NReq),
    .DATA_W    (DW),
    .MAX_BURST (MaxB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  // Requester model: bytes remaining, next byte value, last mode (0 end-of-msg, 1 never, 2 always).
  int         rem   [NReq];
  logic [7:0] dat   [NReq];
  int         lmode [NReq];
  bit         en    [NReq];

  logic [15:0] obs;
  assign obs = {busy, tx_valid, grant_id, tx_data, req_ready};

  function automatic logic [15:0] pk(input logic b, input logic v, input logic [1:0] g,
                                     input logic [7:0] d, input logic [3:0] r);
    return {b, v, g, d, r};
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < NReq; i++) begin
      logic v;
      v = en[i] && (rem[i] > 0);
      req_valid[i]          = v;
      req_data[i*DW +: DW]  = v ? dat[i] : 8'hEE;
      req_last[i]           = v && (lmode[i] == 2 || (lmode[i] == 0 && rem[i] == 1));
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NReq; i++) begin
      rem[i]   = 0;
      dat[i]   = 8'h00;
      lmode[i] = 0;
      en[i]    = 1'b1;
    end
    drive_reqs();
  endtask

  task automatic apply();
    drive_reqs();
    #1;
  endtask

  task automatic adv();
    logic [NReq-1:0] hs;
    hs = req_ready & req_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < NReq; i++) begin
      if (hs[i]) begin
        rem[i]--;
        dat[i]++;
      end
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    tx_ready = 1'b1;
    clear_reqs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    tx_ready = 1'b1;
    clear_reqs();
    rem[0] = 1;
    dat[0] = 8'h11;
    apply();
    if (obs !== pk(0, 0, 0, 8'h00, 4'b0000)) begin
      errors++; $display("FAIL reset_async: got %h want %h", obs, pk(0, 0, 0, 8'h00, 4'b0000));
    end
    checks++;
    @(posedge clk);
    #1;
    apply();
    if (obs !== pk(0, 0, 0, 8'h00, 4'b0000)) begin
      errors++; $display("FAIL reset_held: got %h want %h", obs, pk(0, 0, 0, 8'h00, 4'b0000));
    end
    checks++;
    rst_n = 1'b1;
    #1;
    if (obs !== pk(0, 0, 0, 8'h00, 4'b0000)) begin
      errors++; $display("FAIL reset_released: got %h want %h", obs, pk(0, 0, 0, 8'h00, 4'b0000));
    end
    checks++;
    @(posedge clk);
    #1;
    apply();
    if (obs !== pk(1, 1, 0, 8'h11, 4'b0001)) begin
      errors++; $display("FAIL reset_first_arb: got %h want %h", obs, pk(1, 1, 0, 8'h11, 4'b0001));
    end
    checks++;
  endtask

  task automatic test_two_req();
    logic [15:0] ex [9];
    do_reset();
    rem[0] = 3; dat[0] = 8'hA0;
    rem[2] = 3; dat[2] = 8'hC0;
    ex = '{pk(0, 0, 0, 8'h00, 4'b0000), pk(1, 1, 0, 8'hA0, 4'b0001), pk(1, 1, 0, 8'hA1, 4'b0001),
           pk(1, 1, 0, 8'hA2, 4'b0001), pk(0, 0, 0, 8'h00, 4'b0000), pk(1, 1, 2, 8'hC0, 4'b0100),
           pk(1, 1, 2, 8'hC1, 4'b0100), pk(1, 1, 2, 8'hC2, 4'b0100), pk(0, 0, 2, 8'h00, 4'b0000)};
    for (int c = 0; c < 9; c++) begin
      apply();
      if (obs !== ex[c]) begin
        errors++; $display("FAIL two_req c%0d: got %h want %h", c, obs, ex[c]);
      end
      checks++;
      adv();
    end
  endtask

  task automatic test_burst_limit();
    logic [15:0] e;
    do_reset();
    rem[1] = 100; dat[1] = 8'h10; lmode[1] = 1;
    rem[3] = 2;   dat[3] = 8'h30;
    for (int c = 0; c < 22; c++) begin
      if (c == 0)       e = pk(0, 0, 0, 8'h00, 4'b0000);
      else if (c <= 16) e = pk(1, 1, 1, 8'h10 + 8'(c - 1), 4'b0010);
      else if (c == 17) e = pk(0, 0, 1, 8'h00, 4'b0000);
      else if (c <= 19) e = pk(1, 1, 3, 8'h30 + 8'(c - 18), 4'b1000);
      else if (c == 20) e = pk(0, 0, 3, 8'h00, 4'b0000);
      else              e = pk(1, 1, 1, 8'h20, 4'b0010);
      apply();
      if (obs !== e) begin
        errors++; $display("FAIL burst_limit c%0d: got %h want %h", c, obs, e);
      end
      checks++;
      adv();
    end
  endtask

  task automatic test_wrap();
    logic [15:0] e;
    logic [1:0]  g;
    do_reset();
    for (int i = 0; i < NReq; i++) begin
      rem[i]   = 10;
      dat[i]   = 8'h40 + 8'(16 * i);
      lmode[i] = 2;
    end
    for (int c = 0; c < 10; c++) begin
      if (c % 2 == 1) begin
        g = 2'(((c - 1) / 2) % 4);
        e = pk(1, 1, g, 8'h40 + 8'(16 * int'(g)) + 8'((c - 1) / 8), 4'b0001 << g);
      end else begin
        g = (c == 0) ? 2'd0 : 2'(((c - 2) / 2) % 4);
        e = pk(0, 0, g, 8'h00, 4'b0000);
      end
      apply();
      if (obs !== e) begin
        errors++; $display("FAIL wrap c%0d: got %h want %h", c, obs, e);
      end
      checks++;
      adv();
    end
  endtask

  task automatic test_stall();
    logic [15:0] e;
    do_reset();
    rem[2] = 3; dat[2] = 8'h50;
    for (int c = 0; c < 10; c++) begin
      tx_ready = !(c >= 2 && c <= 6);
      if (c == 0)      e = pk(0, 0, 0, 8'h00, 4'b0000);
      else if (c == 1) e = pk(1, 1, 2, 8'h50, 4'b0100);
      else if (c <= 6) e = pk(1, 1, 2, 8'h51, 4'b0000);
      else if (c == 7) e = pk(1, 1, 2, 8'h51, 4'b0100);
      else if (c == 8) e = pk(1, 1, 2, 8'h52, 4'b0100);
      else             e = pk(0, 0, 2, 8'h00, 4'b0000);
      apply();
      if (obs !== e) begin
        errors++; $display("FAIL stall c%0d: got %h want %h", c, obs, e);
      end
      checks++;
      if (c >= 2 && c <= 6) begin
        if (dut.r_burst_cnt !== 5'd1) begin
          errors++; $display("FAIL stall_cnt c%0d: got %0d want 1", c, dut.r_burst_cnt);
        end
        checks++;
      end
      adv();
    end
    tx_ready = 1'b1;
  endtask

  task automatic test_last_and_max();
    logic [15:0] e;
    do_reset();
    rem[0] = 16; dat[0] = 8'h80;
    rem[1] = 1;  dat[1] = 8'h90;
    for (int c = 0; c < 20; c++) begin
      if (c == 0)       e = pk(0, 0, 0, 8'h00, 4'b0000);
      else if (c <= 16) e = pk(1, 1, 0, 8'h80 + 8'(c - 1), 4'b0001);
      else if (c == 17) e = pk(0, 0, 0, 8'h00, 4'b0000);
      else if (c == 18) e = pk(1, 1, 1, 8'h90, 4'b0010);
      else              e = pk(0, 0, 1, 8'h00, 4'b0000);
      apply();
      if (obs !== e) begin
        errors++; $display("FAIL last_and_max c%0d: got %h want %h", c, obs, e);
      end
      checks++;
      if (c == 16 && dut.r_burst_cnt !== 5'd15) begin
        errors++; $display("FAIL last_and_max_cnt: got %0d want 15", dut.r_burst_cnt);
      end
      if (c == 16) checks++;
      if (c == 17 && dut.r_rr_ptr !== 2'd1) begin
        errors++; $display("FAIL last_and_max_ptr: got %0d want 1", dut.r_rr_ptr);
      end
      if (c == 17) checks++;
      adv();
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    rem[3] = 5; dat[3] = 8'h60;
    apply();
    adv();
    apply();
    if (obs !== pk(1, 1, 3, 8'h60, 4'b1000)) begin
      errors++; $display("FAIL rst_mid_pre: got %h want %h", obs, pk(1, 1, 3, 8'h60, 4'b1000));
    end
    checks++;
    adv();
    apply();
    rst_n = 1'b0;
    #1;
    if (obs !== pk(0, 0, 0, 8'h00, 4'b0000)) begin
      errors++; $display("FAIL rst_mid_async: got %h want %h", obs, pk(0, 0, 0, 8'h00, 4'b0000));
    end
    checks++;
    if (dut.r_burst_cnt !== 5'd0) begin
      errors++; $display("FAIL rst_mid_cnt: got %0d want 0", dut.r_burst_cnt);
    end
    checks++;
    rem[3] = 0;
    drive_reqs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      apply();
      if (obs !== pk(0, 0, 0, 8'h00, 4'b0000)) begin
        errors++; $display("FAIL rst_mid_noreplay c%0d: got %h want %h", c, obs,
                           pk(0, 0, 0, 8'h00, 4'b0000));
      end
      checks++;
      adv();
    end
  endtask

  task automatic test_drop_valid();
    logic [15:0] e;
    do_reset();
    rem[1] = 4; dat[1] = 8'h70;
    rem[2] = 1; dat[2] = 8'hD0;
    for (int c = 0; c < 10; c++) begin
      en[1] = !(c >= 2 && c <= 4);
      if (c == 0)      e = pk(0, 0, 0, 8'h00, 4'b0000);
      else if (c == 1) e = pk(1, 1, 1, 8'h70, 4'b0010);
      else if (c <= 4) e = pk(1, 0, 1, 8'h00, 4'b0010);
      else if (c <= 7) e = pk(1, 1, 1, 8'h71 + 8'(c - 5), 4'b0010);
      else if (c == 8) e = pk(0, 0, 1, 8'h00, 4'b0000);
      else             e = pk(1, 1, 2, 8'hD0, 4'b0100);
      apply();
      if (obs !== e) begin
        errors++; $display("FAIL drop_valid c%0d: got %h want %h", c, obs, e);
      end
      checks++;
      adv();
    end
  endtask

  initial begin
    test_reset();
    test_two_req();
    test_burst_limit();
    test_wrap();
    test_stall();
    test_last_and_max();
    test_reset_mid_grant();
    test_drop_valid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
